exit_collector: RTL and testbench
=================================

# exit_collector

Parametrised exit-queue collector between the per-cell force/position outputs of `simulator` and the host dump path of `init_axis`. It replaces the fixed 15-slot pair time-multiplex with lossless buffering:
- Each of `N_CH` channels gets a `DEPTH`-entry FIFO.
- A round-robin packer fills up to `LANES` records per output beat, skipping idle channels.
- The output stream carries valid/ready backpressure.
- A flush command appends the terminator record and marks the last beat.

## Interface
Parameters:
- `N_CH`, 27 — number of input channels (cells).
- `REC_W`, 97 — record width in bits.
- `LANES`, 2 — records per output beat; must be ≥1 and ≤ `N_CH`.
- `DEPTH`, 4 — entries per channel FIFO; must be a power of two ≥2.

Ports:
- `clk`, in, 1 — single clock; all logic on the rising edge.
- `rst`, in, 1 — synchronous, active-high reset.
- `i_rec_data`, in, `N_CH*REC_W` — channel c occupies bits [c*REC_W +: REC_W].
- `i_rec_valid`, in, `N_CH` — per-channel push strobe. There is no ready; the producer never stalls.
- `i_flush`, in, 1 — one-cycle pulse requesting drain plus terminator.
- `i_clr_ovf`, in, 1 — clears all overflow flags.
- `o_tdata`, out, `LANES*REC_W` — lane k occupies bits [k*REC_W +: REC_W].
- `o_tkeep`, out, `LANES` — per-lane record valid.
- `o_tvalid`, out, 1 — beat valid.
- `o_tlast`, out, 1 — set only on the terminator beat.
- `i_tready`, in, 1 — downstream accept.
- `o_overflow`, out, `N_CH` — sticky per-channel drop flag.
- `o_flush_done`, out, 1 — one-cycle pulse when the terminator beat is accepted.
- `o_busy`, out, 1 — high while any FIFO is non-empty, the output beat is valid, or a flush is pending.

## Operation
- **Push.** A channel with `i_rec_valid` set writes its record into its FIFO.
  - If the FIFO is full and not popped in the same cycle, the record is dropped and `o_overflow[c]` is set.
  - A full FIFO that is popped in the same cycle accepts the push.
- **Output register.** The register is "free" when `o_tvalid`=0 or `i_tready`=1.
  - When free, the packer scans channels starting at `rr_ptr` in ascending order, modulo `N_CH`.
  - It grants the first `LANES` non-empty FIFOs and pops one record from each.
  - Granted records fill lanes 0,1,… in scan order. Unfilled lanes have `o_tkeep`=0 and data zero.
  - `rr_ptr` moves to (last granted channel + 1) mod `N_CH`. With zero grants, `rr_ptr` holds and `o_tvalid` drops to 0 (if the held beat was accepted).
- **Stall.** While `o_tvalid`=1 and `i_tready`=0, `o_tdata`, `o_tkeep` and `o_tlast` hold stable. No pops occur.
- **Flush.**
  - `i_flush` sets `flush_pending`. Pushes continue to be accepted and drained normally.
  - When `flush_pending` is set, all FIFOs are empty and the register is free, the register loads the terminator beat:
    - lane 0 = {1'b1, (`REC_W`-1)'b0}, `o_tkeep`=1 (lane 0 only), `o_tlast`=1.
  - When the terminator is accepted: `o_flush_done` pulses, and `flush_pending` clears.
  - Records pushed in the same cycle as the terminator load are packed in later beats, after the terminator.
  - `i_flush` while already pending is ignored.
- **Overflow flags.** `i_clr_ovf` clears all flags. A drop in the same cycle as the clear sets that flag (the set wins).
- **Reset.** Any cycle with `rst`=1, including mid-beat or mid-flush:
  - empties all FIFOs, sets `rr_ptr`=0, clears `flush_pending`;
  - discards any held beat without handshake.

## Timing
- Reset values: `o_tvalid`=0, `o_tlast`=0, `o_tkeep`=0, `o_tdata`=0, `o_overflow`=0, `o_flush_done`=0, `o_busy`=0.
- Latency: a push at cycle t into an empty FIFO, with the register free and the channel first in scan order, gives `o_tvalid`=1 at cycle t+2.
- Throughput: `LANES` records per cycle under continuous `i_tready`.
- `o_flush_done` is asserted in the cycle after the terminator handshake.
- FIFO occupancy counters are `$clog2(DEPTH)+1` bits. Read and write pointers wrap modulo `DEPTH`.
- `rr_ptr` is `$clog2(N_CH)` bits and wraps from `N_CH`-1 to 0.

## Test plan
- **Single record.** Defaults; `rr_ptr`=0, ch5 pushes 0x1 at t, `i_tready`=1 → at t+2: `o_tvalid`=1, lane0=0x1, `o_tkeep`=2'b01, `o_tlast`=0. `rr_ptr` then equals 6.
- **Round-robin wrap.** Channels 3, 20 and 26 each push one record in the same cycle, `rr_ptr`=21 → beat 1 = {lane0 ch26, lane1 ch3}, beat 2 = {lane0 ch20, `o_tkeep`=01}.
- **Backpressure.** All 27 channels push once, `i_tready` held 0 for 10 cycles → first beat is stable for all 10 cycles with no pops and no overflow. After release, 14 beats emit 27 records in channel order 0..26.
- **Overflow.** ch0 pushes 5 consecutive cycles, `i_tready`=0 → `o_overflow[0]`=1 after the 5th push. Only 4 records are eventually output. `i_clr_ovf` then clears the flag.
- **Flush.** 3 records buffered, `i_flush` pulsed, `i_tready`=1 → 2 data beats, then terminator lane0 = 1<<96 with `o_tlast`=1. `o_flush_done` pulses the next cycle and `o_busy` falls.
- **Reset mid-stream.** `rst`=1 for 1 cycle while `o_tvalid`=1 with a stalled beat and 8 records buffered → next cycle all outputs are at reset values. The next push emerges 2 cycles later on lane 0.

Source files
------------

// File: rtl/exit_collector.sv
// Exit-queue collector: per-channel record FIFOs drained by a round-robin packer into a
// LANES-wide valid/ready output beat, with a flush terminator and sticky overflow flags.
module exit_collector #(
    parameter int N_CH  = 27,
    parameter int REC_W = 97,
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*REC_W-1:0]  i_rec_data,
    input  logic [N_CH-1:0]        i_rec_valid,
    input  logic                   i_flush,
    input  logic                   i_clr_ovf,
    output logic [LANES*REC_W-1:0] o_tdata,
    output logic [LANES-1:0]       o_tkeep,
    output logic                   o_tvalid,
    output logic                   o_tlast,
    input  logic                   i_tready,
    output logic [N_CH-1:0]        o_overflow,
    output logic                   o_flush_done,
    output logic                   o_busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*REC_W-1:0]  head_s;
    logic [N_CH-1:0]        nonempty_s;
    logic [N_CH-1:0]        nonempty_d_s;
    logic [N_CH-1:0]        pop_s;
    logic [N_CH-1:0]        drop_s;

    logic [LANES*REC_W-1:0] lane_data_s;
    logic [LANES-1:0]       lane_keep_s;
    logic                   grant_s;
    logic [PW-1:0]          last_ch_s;

    logic                   free_s;
    logic                   pack_en_s;
    logic                   term_load_s;
    logic                   term_acc_s;

    logic [LANES*REC_W-1:0] tdata_q, tdata_d;
    logic [LANES-1:0]       tkeep_q, tkeep_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [N_CH-1:0]        overflow_q, overflow_d;
    logic                   flush_done_q, flush_done_d;
    logic                   busy_q, busy_d;
    logic                   flush_pending_q, flush_pending_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [REC_W-1:0] mem_q [DEPTH];
        logic [REC_W-1:0] mem_d [DEPTH];
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             full_s;
        logic             push_s;
        logic             drop_l_s;

        // A full FIFO still takes a push when its head leaves in the same cycle
        always_comb begin
            full_s   = (cnt_q == CW'(DEPTH));
            push_s   = i_rec_valid[g] && (!full_s || pop_s[g]);
            drop_l_s = i_rec_valid[g] && full_s && !pop_s[g];
            mem_d    = mem_q;
            if (push_s) begin
                mem_d[wr_ptr_q] = i_rec_data[g*REC_W +: REC_W];
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s[g]) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s[g]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Record storage carries no reset; only pointers and count are cleared
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end

        // FIFO pointer and occupancy registers
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        assign head_s[g*REC_W +: REC_W] = mem_q[rd_ptr_q];
        assign nonempty_s[g]            = (cnt_q != '0);
        assign nonempty_d_s[g]          = (cnt_d != '0);
        assign drop_s[g]                = drop_l_s;
    end

    // Round-robin packer: grant the first LANES non-empty channels scanning up from rr_ptr
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] ch;
        int            n_grant;
        pop_s       = '0;
        lane_data_s = '0;
        lane_keep_s = '0;
        grant_s     = 1'b0;
        last_ch_s   = rr_ptr_q;
        n_grant     = 0;
        sum         = '0;
        ch          = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N_CH)) begin
                sum = sum - (PW+1)'(N_CH);
            end else begin
                sum = sum;
            end
            ch = sum[PW-1:0];
            if (pack_en_s && nonempty_s[ch] && (n_grant < LANES)) begin
                pop_s[ch] = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    if (k == n_grant) begin
                        lane_data_s[k*REC_W +: REC_W] = head_s[ch*REC_W +: REC_W];
                        lane_keep_s[k]                = 1'b1;
                    end else begin
                        lane_keep_s[k] = lane_keep_s[k];
                    end
                end
                last_ch_s = ch;
                grant_s   = 1'b1;
                n_grant   = n_grant + 1;
            end else begin
                n_grant = n_grant;
            end
        end
    end

    // Output beat, flush sequencing, overflow flags and busy
    always_comb begin
        free_s      = !tvalid_q || i_tready;
        term_acc_s  = tvalid_q && tlast_q && i_tready;
        // A terminator being accepted must not immediately reload itself
        term_load_s = flush_pending_q && !(|nonempty_s) && free_s && !tlast_q;
        pack_en_s   = free_s && !term_load_s;

        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (term_load_s) begin
            tdata_d            = '0;
            tdata_d[REC_W-1]   = 1'b1;
            tkeep_d            = LANES'(1);
            tlast_d            = 1'b1;
            tvalid_d           = 1'b1;
        end else if (free_s) begin
            tdata_d  = lane_data_s;
            tkeep_d  = lane_keep_s;
            tlast_d  = 1'b0;
            tvalid_d = grant_s;
        end else begin
            tvalid_d = tvalid_q;
        end

        if (grant_s) begin
            rr_ptr_d = (last_ch_s == PW'(N_CH - 1)) ? '0 : last_ch_s + PW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (term_acc_s) begin
            flush_pending_d = 1'b0;
        end else if (i_flush) begin
            flush_pending_d = 1'b1;
        end else begin
            flush_pending_d = flush_pending_q;
        end
        flush_done_d = term_acc_s;

        if (i_clr_ovf) begin
            overflow_d = drop_s;
        end else begin
            overflow_d = overflow_q | drop_s;
        end

        busy_d = (|nonempty_d_s) || tvalid_d || flush_pending_d;
    end

    // Control and output registers; reset drops any held beat without handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q         <= '0;
            tkeep_q         <= '0;
            tvalid_q        <= 1'b0;
            tlast_q         <= 1'b0;
            overflow_q      <= '0;
            flush_done_q    <= 1'b0;
            busy_q          <= 1'b0;
            flush_pending_q <= 1'b0;
            rr_ptr_q        <= '0;
        end else begin
            tdata_q         <= tdata_d;
            tkeep_q         <= tkeep_d;
            tvalid_q        <= tvalid_d;
            tlast_q         <= tlast_d;
            overflow_q      <= overflow_d;
            flush_done_q    <= flush_done_d;
            busy_q          <= busy_d;
            flush_pending_q <= flush_pending_d;
            rr_ptr_q        <= rr_ptr_d;
        end
    end

    assign o_tdata      = tdata_q;
    assign o_tkeep      = tkeep_q;
    assign o_tvalid     = tvalid_q;
    assign o_tlast      = tlast_q;
    assign o_overflow   = overflow_q;
    assign o_flush_done = flush_done_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_exit_collector.sv
// Bench for exit_collector: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_exit_collector;
    localparam int N_CH  = 27;
    localparam int REC_W = 97;
    localparam int LANES = 2;
    localparam int DEPTH = 4;

    typedef logic [REC_W-1:0] rec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH*REC_W-1:0]  i_rec_data;
    logic [N_CH-1:0]        i_rec_valid;
    logic                   i_flush;
    logic                   i_clr_ovf;
    logic [LANES*REC_W-1:0] o_tdata;
    logic [LANES-1:0]       o_tkeep;
    logic                   o_tvalid;
    logic                   o_tlast;
    logic                   i_tready;
    logic [N_CH-1:0]        o_overflow;
    logic                   o_flush_done;
    logic                   o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    exit_collector #(.N_CH(N_CH), .REC_W(REC_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_rec_data(i_rec_data), .i_rec_valid(i_rec_valid),
        .i_flush(i_flush), .i_clr_ovf(i_clr_ovf), .o_tdata(o_tdata), .o_tkeep(o_tkeep),
        .o_tvalid(o_tvalid), .o_tlast(o_tlast), .i_tready(i_tready),
        .o_overflow(o_overflow), .o_flush_done(o_flush_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic rec_t rec(int c, int s);
        rec_t r;
        r        = '0;
        r[15:0]  = 16'(s);
        r[23:16] = 8'(c);
        r[95:64] = 32'hC0DE0000 | 32'(c);
        return r;
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    rec_t                   mq [N_CH][$];
    logic [LANES*REC_W-1:0] m_data;
    logic [LANES-1:0]       m_keep;
    logic                   m_valid, m_last, m_done, m_busy, m_fp;
    logic [N_CH-1:0]        m_ovf;
    int                     m_rr;

    function automatic bit model_empty();
        for (int c = 0; c < N_CH; c++) if (mq[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        logic free, acc_term, fp_pre;
        int   n, ch, new_rr;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) mq[c].delete();
            m_rr = 0; m_fp = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_data = '0;
            m_keep = '0; m_ovf = '0; m_done = 1'b0; m_busy = 1'b0;
        end else begin
            free     = !m_valid || i_tready;
            acc_term = m_valid && m_last && i_tready;
            fp_pre   = m_fp;
            m_done   = acc_term;
            if (acc_term) m_fp = 1'b0;
            if (free) begin
                m_data = '0; m_keep = '0; m_last = 1'b0; m_valid = 1'b0;
                if (m_fp && model_empty()) begin
                    m_data[REC_W-1] = 1'b1; m_keep[0] = 1'b1; m_last = 1'b1; m_valid = 1'b1;
                end else begin
                    n = 0; new_rr = m_rr;
                    for (int j = 0; j < N_CH; j++) begin
                        ch = (m_rr + j) % N_CH;
                        if (n < LANES && mq[ch].size() > 0) begin
                            m_data[n*REC_W +: REC_W] = mq[ch].pop_front();
                            m_keep[n] = 1'b1;
                            n++;
                            new_rr = (ch + 1) % N_CH;
                        end
                    end
                    m_rr    = new_rr;
                    m_valid = (n > 0);
                end
            end
            if (i_clr_ovf) m_ovf = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (i_rec_valid[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(i_rec_data[c*REC_W +: REC_W]);
                    else m_ovf[c] = 1'b1;
                end
            end
            if (i_flush && !fp_pre) m_fp = 1'b1;
            m_busy = m_valid || m_fp || !model_empty();
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tvalid", 256'(o_tvalid), 256'(m_valid));
            chk("model_tkeep", 256'(o_tkeep), 256'(m_keep));
            chk("model_tlast", 256'(o_tlast), 256'(m_last));
            chk("model_tdata", 256'(o_tdata), 256'(m_data));
            chk("model_overflow", 256'(o_overflow), 256'(m_ovf));
            chk("model_flush_done", 256'(o_flush_done), 256'(m_done));
            chk("model_busy", 256'(o_busy), 256'(m_busy));
        end
    end

    // Accepted-beat monitor: data records and terminator count
    rec_t                   rec_log [$];
    int                     term_cnt = 0;
    always @(posedge clk) begin
        if (!rst && o_tvalid && i_tready) begin
            if (o_tlast) term_cnt++;
            else for (int k = 0; k < LANES; k++)
                if (o_tkeep[k]) rec_log.push_back(o_tdata[k*REC_W +: REC_W]);
        end
    end

    task automatic expect_rec(string nm, rec_t exp);
        int k;
        k = 0;
        while (rec_log.size() == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (rec_log.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no record within 100 cycles, expected %h", nm, exp);
        end else begin
            chk(nm, 256'(rec_log.pop_front()), 256'(exp));
        end
    endtask

    task automatic set_push(logic [N_CH-1:0] mask, int s);
        for (int c = 0; c < N_CH; c++) i_rec_data[c*REC_W +: REC_W] = rec(c, s);
        i_rec_valid = mask;
    endtask

    logic [LANES*REC_W-1:0] exp_beat;
    logic [N_CH-1:0]        mask;
    int                     k;

    initial begin
        rst = 1'b1; i_rec_data = '0; i_rec_valid = '0; i_flush = 1'b0;
        i_clr_ovf = 1'b0; i_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_tvalid", 256'(o_tvalid), 256'(0));
        chk("reset_tdata", 256'(o_tdata), 256'(0));
        chk("reset_busy", 256'(o_busy), 256'(0));

        // Single record: latency of two cycles, lane 0
        i_rec_data[5*REC_W +: REC_W] = rec_t'(1);
        i_rec_valid = N_CH'(1) << 5;
        @(negedge clk);
        i_rec_valid = '0;
        chk("single_t1_tvalid", 256'(o_tvalid), 256'(0));
        @(negedge clk);
        chk("single_t2_tvalid", 256'(o_tvalid), 256'(1));
        chk("single_t2_lane0", 256'(o_tdata[REC_W-1:0]), 256'(1));
        chk("single_t2_tkeep", 256'(o_tkeep), 256'(2'b01));
        chk("single_t2_tlast", 256'(o_tlast), 256'(0));
        expect_rec("single_rec", rec_t'(1));

        // rr_ptr is now 6: ch7 before ch3
        set_push((N_CH'(1) << 3) | (N_CH'(1) << 7), 2);
        @(negedge clk);
        i_rec_valid = '0;
        expect_rec("rr6_first", rec(7, 2));
        expect_rec("rr6_second", rec(3, 2));

        // Move rr_ptr to 21, then wrap across the top
        set_push(N_CH'(1) << 20, 3);
        @(negedge clk);
        i_rec_valid = '0;
        expect_rec("rr21_setup", rec(20, 3));
        set_push((N_CH'(1) << 3) | (N_CH'(1) << 20) | (N_CH'(1) << 26), 4);
        @(negedge clk);
        i_rec_valid = '0;
        @(negedge clk);
        exp_beat = {rec(3, 4), rec(26, 4)};
        chk("wrap_beat1", 256'(o_tdata), 256'(exp_beat));
        @(negedge clk);
        exp_beat = {rec_t'(0), rec(20, 4)};
        chk("wrap_beat2", 256'(o_tdata), 256'(exp_beat));
        chk("wrap_beat2_keep", 256'(o_tkeep), 256'(2'b01));
        expect_rec("wrap_r0", rec(26, 4));
        expect_rec("wrap_r1", rec(3, 4));
        expect_rec("wrap_r2", rec(20, 4));

        // Return rr_ptr to 0
        set_push(N_CH'(1) << 26, 5);
        @(negedge clk);
        i_rec_valid = '0;
        expect_rec("rr0_setup", rec(26, 5));

        // Backpressure: all channels push once, beat held for 10 cycles
        i_tready = 1'b0;
        set_push({N_CH{1'b1}}, 6);
        @(negedge clk);
        i_rec_valid = '0;
        @(negedge clk);
        exp_beat = {rec(1, 6), rec(0, 6)};
        for (int i = 0; i < 10; i++) begin
            chk("stall_beat_stable", 256'(o_tdata), 256'(exp_beat));
            chk("stall_no_overflow", 256'(o_overflow), 256'(0));
            @(negedge clk);
        end
        i_tready = 1'b1;
        for (int c = 0; c < N_CH; c++) expect_rec("stall_order", rec(c, 6));

        // Overflow: register stalled with ch1, then ch0 pushes five times
        i_tready = 1'b0;
        set_push(N_CH'(1) << 1, 7);
        @(negedge clk);
        i_rec_valid = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("ovf_after4", 256'(o_overflow[0]), 256'(0));
            set_push(N_CH'(1), 80 + i);
            @(negedge clk);
        end
        i_rec_valid = '0;
        chk("ovf_after5", 256'(o_overflow[0]), 256'(1));
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        chk("ovf_cleared", 256'(o_overflow), 256'(0));
        set_push(N_CH'(1), 90);
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_rec_valid = '0;
        i_clr_ovf = 1'b0;
        chk("ovf_set_wins", 256'(o_overflow[0]), 256'(1));
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        chk("ovf_cleared2", 256'(o_overflow), 256'(0));
        i_tready = 1'b1;
        expect_rec("ovf_r_ch1", rec(1, 7));
        for (int i = 0; i < 4; i++) expect_rec("ovf_r_ch0", rec(0, 80 + i));

        // Flush: three records, then terminator; a flush in the accept cycle is ignored
        set_push((N_CH'(1) << 4) | (N_CH'(1) << 5) | (N_CH'(1) << 6), 9);
        i_flush = 1'b1;
        @(negedge clk);
        i_rec_valid = '0;
        i_flush = 1'b0;
        chk("flush_busy", 256'(o_busy), 256'(1));
        k = 0;
        while (!o_tlast && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("flush_term_seen", 256'(o_tlast), 256'(1));
        exp_beat = '0;
        exp_beat[REC_W-1] = 1'b1;
        chk("flush_term_data", 256'(o_tdata), 256'(exp_beat));
        chk("flush_term_keep", 256'(o_tkeep), 256'(2'b01));
        chk("flush_done_early", 256'(o_flush_done), 256'(0));
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_done_pulse", 256'(o_flush_done), 256'(1));
        chk("flush_busy_low", 256'(o_busy), 256'(0));
        @(negedge clk);
        chk("flush_done_one_cycle", 256'(o_flush_done), 256'(0));
        expect_rec("flush_r0", rec(4, 9));
        expect_rec("flush_r1", rec(5, 9));
        expect_rec("flush_r2", rec(6, 9));
        repeat (8) @(negedge clk);
        chk("flush_single_term", 256'(term_cnt), 256'(1));

        // Reset mid-stream with a stalled beat and eight buffered records
        i_tready = 1'b0;
        mask = '0;
        for (int c = 0; c < 10; c++) mask[c] = 1'b1;
        set_push(mask, 10);
        @(negedge clk);
        i_rec_valid = '0;
        @(negedge clk);
        chk("pre_reset_tvalid", 256'(o_tvalid), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_tvalid", 256'(o_tvalid), 256'(0));
        chk("mid_reset_tkeep", 256'(o_tkeep), 256'(0));
        chk("mid_reset_tdata", 256'(o_tdata), 256'(0));
        chk("mid_reset_busy", 256'(o_busy), 256'(0));
        set_push(N_CH'(1) << 9, 11);
        @(negedge clk);
        i_rec_valid = '0;
        chk("post_reset_t1", 256'(o_tvalid), 256'(0));
        @(negedge clk);
        chk("post_reset_t2_valid", 256'(o_tvalid), 256'(1));
        chk("post_reset_t2_lane0", 256'(o_tdata[REC_W-1:0]), 256'(rec(9, 11)));
        chk("post_reset_t2_keep", 256'(o_tkeep), 256'(2'b01));
        i_tready = 1'b1;
        expect_rec("post_reset_rec", rec(9, 11));
        repeat (10) @(negedge clk);
        chk("post_reset_no_stale", 256'(rec_log.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
